bcd_serial_sequencer: RTL and testbench
=======================================

BCD_SERIAL_SEQUENCER -- requirements
Module: bcd_serial_sequencer

Interface
REQ-001 SHALL have parameter DIGITS, default 4, giving the number of BCD digits per operand (legal range 2..8).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request to add a and b; sampled only in IDLE.
REQ-005 SHALL have port a, input, 4*DIGITS bits: packed BCD operand A; digit 0 is in a[3:0].
REQ-006 SHALL have port b, input, 4*DIGITS bits: packed BCD operand B; same packing as a.
REQ-007 SHALL have port busy, output, 1 bit: high in RUN and DONE.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse marking sum, cout and err valid.
REQ-009 SHALL have port sum, output, 4*DIGITS bits: packed BCD result.
REQ-010 SHALL have port cout, output, 1 bit: decimal carry out of the most-significant digit.
REQ-011 SHALL have port err, output, 1 bit: at least one operand digit was greater than 9.

Function
REQ-012 SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-013 In IDLE with start=1, SHALL latch a and b into internal operand registers, clear the digit index and carry, and check every digit.
- All digits <= 9: next state RUN.
- Any digit > 9: next state DONE, with sum=0, cout=0 and err=1 loaded.
REQ-014 In IDLE with start=0, SHALL hold state, sum, cout and err unchanged.
REQ-015 In RUN, SHALL process exactly one digit per clock, starting at index 0 and working upward.
REQ-016 The per-digit datapath SHALL be as follows.
- t = A[i] + B[i] + carry, computed as a 5-bit value.
- If t > 9: the result digit is t+6 truncated to 4 bits, and the next carry is 1.
- Otherwise: the result digit is t, and the next carry is 0.
REQ-017 SHALL write each result digit into an internal accumulator; the sum port SHALL NOT change during RUN.
REQ-018 On the edge that processes index DIGITS-1, SHALL transfer the accumulator to sum, the final carry to cout and 0 to err, then enter DONE.
REQ-019 In DONE, SHALL assert done=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-020 Latency for valid operands: done SHALL be high in the cycle after the (DIGITS+1)th rising edge, counting the start-sampling edge as edge 1.
REQ-021 Latency for invalid operands: done SHALL be high in the cycle after the start-sampling edge.
REQ-022 SHALL ignore start while in RUN or DONE (no queueing), and SHALL ignore changes on a and b after the start-sampling edge.
REQ-023 A start held high across the DONE-to-IDLE transition SHALL begin a new operation on the first IDLE edge that samples it.
REQ-024 sum, cout and err SHALL hold their last values from the end of DONE until the next operation completes.
REQ-025 The busy output SHALL be registered or decoded from state only, with no combinational path from start.

Reset
REQ-026 While rst=1, SHALL force the state to IDLE and drive done=0, busy=0, sum=0, cout=0 and err=0, regardless of clk.
REQ-027 Reset asserted mid-RUN SHALL abort the operation with no done pulse; the first start after reset release SHALL begin a fresh operation.

Verification (DIGITS=4)
REQ-028 a=0x1234, b=0x5678, start pulsed -> done in the cycle after edge 5 with sum=0x6912, cout=0, err=0; busy high for 5 cycles.
REQ-029 a=0x9999, b=0x0001 -> sum=0x0000, cout=1, err=0 (full carry ripple); a=0x9999, b=0x9999 -> sum=0x9998, cout=1.
REQ-030 a=0x12A4, b=0x0001 -> done in the cycle after edge 1 with sum=0x0000, cout=0, err=1; no RUN cycles.
REQ-031 start re-pulsed with a=0x1111 during RUN of 0x0005+0x0005 -> sum=0x0010, exactly one done pulse; a follow-up start in IDLE is then accepted.
REQ-032 rst asserted at the 2nd RUN cycle of 0x4321+0x1111, then released -> all outputs 0, no done pulse; next start with 0x0001+0x0002 -> sum=0x0003.

Source files
------------

// File: rtl/bcd_serial_sequencer.sv
// Serial BCD adder: adds two packed DIGITS-digit BCD operands one digit per
// clock, least-significant digit first. Operands with a non-decimal digit are
// rejected up front and reported through err without entering RUN.
module bcd_serial_sequencer #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  err
);

    localparam int IW = $clog2(DIGITS);
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [4*DIGITS-1:0] a_q, a_d;
    logic [4*DIGITS-1:0] b_q, b_d;
    logic [4*DIGITS-1:0] acc_q, acc_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic                carry_q, carry_d;
    logic [4*DIGITS-1:0] sum_q, sum_d;
    logic                cout_q, cout_d;
    logic                err_q, err_d;

    logic                operand_bad;
    logic [3:0]          a_dig, b_dig, res_dig;
    logic [4:0]          t;
    logic                carry_nxt;

    // Flag any non-decimal digit on the live operand inputs
    always_comb begin
        operand_bad = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) begin
                operand_bad = 1'b1;
            end
        end
    end

    // Single-digit decimal add on the currently indexed digit
    always_comb begin
        a_dig = a_q[{idx_q, 2'b00} +: 4];
        b_dig = b_q[{idx_q, 2'b00} +: 4];
        t     = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0000, carry_q};
        if (t > 5'd9) begin
            res_dig   = t[3:0] + 4'd6;
            carry_nxt = 1'b1;
        end else begin
            res_dig   = t[3:0];
            carry_nxt = 1'b0;
        end
    end

    // Next-state and datapath register updates
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    idx_d   = '0;
                    carry_d = 1'b0;
                    if (operand_bad) begin
                        sum_d   = '0;
                        cout_d  = 1'b0;
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                acc_d[{idx_q, 2'b00} +: 4] = res_dig;
                carry_d = carry_nxt;
                idx_d   = idx_q + 1'b1;
                // The final digit goes straight into sum alongside the
                // accumulator update so the result is visible in DONE.
                if (idx_q == LAST_IDX) begin
                    sum_d   = acc_d;
                    cout_d  = carry_nxt;
                    err_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
        end
    end

    // Status outputs decoded from state only
    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
        sum  = sum_q;
        cout = cout_q;
        err  = err_q;
    end

endmodule

// File: tb/tb_bcd_serial_sequencer.sv
// Directed bench for bcd_serial_sequencer with DIGITS=4.
module tb_bcd_serial_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        err;

    int          n_cmp;
    int          n_bad;
    logic [15:0] prev_sum;

    bcd_serial_sequencer #(.DIGITS(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expectation
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Run one operation and check latency, result, and quiet idle afterwards
    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_v,
                         input logic [15:0] es, input logic ec, input logic ee,
                         input int elat, input int repulse_edge);
        int done_edge;
        int busy_cnt;
        int post_done;
        int post_busy;
        int post_sum_bad;
        @(negedge clk);
        a     = ta;
        b     = tb_v;
        start = 1'b1;
        done_edge = 0;
        busy_cnt  = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                start = 1'b0;
                a = 16'h7777;
                b = 16'h2222;
            end
            if (k == repulse_edge) begin
                start = 1'b1;
                a = 16'h1111;
            end
            if (k == repulse_edge + 1) start = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin
                done_edge = k;
                break;
            end
            check_eq("sum_hold_run", {16'h0, sum}, {16'h0, prev_sum});
        end
        check_eq("latency", done_edge, elat);
        check_eq("sum", {16'h0, sum}, {16'h0, es});
        check_eq("cout_err", {30'h0, cout, err}, {30'h0, ec, ee});
        check_eq("busy_cycles", busy_cnt, elat);
        post_done = 0;
        post_busy = 0;
        post_sum_bad = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (done) post_done++;
            if (busy) post_busy++;
            if (sum !== es) post_sum_bad++;
        end
        check_eq("post_done_pulses", post_done, 0);
        check_eq("post_busy", post_busy, 0);
        check_eq("post_sum_held", post_sum_bad, 0);
        prev_sum = es;
    endtask

    initial begin
        int extra_done;
        int extra_busy;
        n_cmp    = 0;
        n_bad    = 0;
        prev_sum = 16'h0000;
        rst   = 1'b1;
        start = 1'b0;
        a     = 16'h0000;
        b     = 16'h0000;
        #1;
        check_eq("reset_outputs", {13'h0, done, busy, cout, err, sum}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        do_op(16'h1234, 16'h5678, 16'h6912, 1'b0, 1'b0, 5, -1);
        do_op(16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b0, 5, -1);
        do_op(16'h9999, 16'h9999, 16'h9998, 1'b1, 1'b0, 5, -1);
        do_op(16'h12A4, 16'h0001, 16'h0000, 1'b0, 1'b1, 1, -1);
        do_op(16'h0001, 16'hF000, 16'h0000, 1'b0, 1'b1, 1, -1);
        do_op(16'h0005, 16'h0005, 16'h0010, 1'b0, 1'b0, 5, 2);
        do_op(16'h0100, 16'h0899, 16'h0999, 1'b0, 1'b0, 5, -1);

        // Reset in the second RUN cycle aborts the operation
        @(negedge clk);
        a     = 16'h4321;
        b     = 16'h1111;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_eq("mid_run_reset", {13'h0, done, busy, cout, err, sum}, 32'h0);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        extra_done = 0;
        extra_busy = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (done) extra_done++;
            if (busy) extra_busy++;
        end
        check_eq("abort_no_done", extra_done, 0);
        check_eq("abort_no_busy", extra_busy, 0);
        check_eq("abort_outputs", {14'h0, cout, err, sum}, 32'h0);
        prev_sum = 16'h0000;
        do_op(16'h0001, 16'h0002, 16'h0003, 1'b0, 1'b0, 5, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
